// File: rtl/count_7sd_multi.sv
// Multi-digit hex/BCD counter with a mode state machine and per-digit
// registered active-low seven-segment outputs.
module count_7sd_multi #(
  parameter int NUM_DIGITS = 2,
  parameter bit BCD        = 1'b0,
  parameter int TICK_DIV   = 25000000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_Mode_Next,
  input  logic                    i_Step,
  input  logic                    i_Dir,
  input  logic                    i_Clear,
  output logic [4*NUM_DIGITS-1:0] o_Count,
  output logic [7*NUM_DIGITS-1:0] o_Segments,
  output logic [1:0]              o_Mode
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AUTO = 2'd1,
    STEP = 2'd2,
    HOLD = 2'd3
  } mode_t;

  localparam int              PW         = $clog2(TICK_DIV);
  localparam int              BW         = $clog2(BLINK_DIV);
  localparam logic [PW-1:0]   TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [3:0]      DIGIT_MAX  = BCD ? 4'd9 : 4'd15;

  mode_t                   mode_r;
  logic [4*NUM_DIGITS-1:0] count_r;
  logic [7*NUM_DIGITS-1:0] seg_r;
  logic [7*NUM_DIGITS-1:0] seg_next_s;
  logic [PW-1:0]           presc_r;
  logic [BW-1:0]           blink_cnt_r;
  logic                    blink_on_r;
  logic                    mode_prev_r;
  logic                    step_prev_r;
  logic                    armed_r;
  logic                    step_pend_r;
  logic                    mode_edge_s;
  logic                    step_edge_s;
  logic                    advance_s;
  mode_t                   mode_next_s;

  function automatic logic [4*NUM_DIGITS-1:0] step_count(
    input logic [4*NUM_DIGITS-1:0] cur,
    input logic                    down
  );
    logic [4*NUM_DIGITS-1:0] res;
    logic                    carry;
    logic [3:0]              d;
    res   = cur;
    carry = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      d = cur[4*k +: 4];
      if (!carry) begin
        res[4*k +: 4] = d;
      end else if (down) begin
        if (d == 4'd0) begin
          res[4*k +: 4] = DIGIT_MAX;
        end else begin
          res[4*k +: 4] = d - 4'd1;
          carry         = 1'b0;
        end
      end else begin
        if (d == DIGIT_MAX) begin
          res[4*k +: 4] = 4'd0;
        end else begin
          res[4*k +: 4] = d + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // Active-high glyphs, segment A in bit 0 through G in bit 6.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h7C;
      4'hC:    g = 7'h39;
      4'hD:    g = 7'h5E;
      4'hE:    g = 7'h79;
      4'hF:    g = 7'h71;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // armed_r blocks a false edge from an input already high at reset release
  assign mode_edge_s = armed_r & i_Mode_Next & ~mode_prev_r;
  assign step_edge_s = armed_r & i_Step & ~step_prev_r;
  assign mode_next_s = mode_t'(mode_r + 2'd1);
  assign advance_s   = ((mode_r == AUTO) && (presc_r == TICK_LAST)) ||
                       ((mode_r == STEP) && step_pend_r);

  // Edge history, mode FSM, prescaler, blink timer and count register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      mode_r      <= IDLE;
      count_r     <= '0;
      presc_r     <= '0;
      blink_cnt_r <= '0;
      blink_on_r  <= 1'b1;
      mode_prev_r <= 1'b0;
      step_prev_r <= 1'b0;
      armed_r     <= 1'b0;
      step_pend_r <= 1'b0;
    end else begin
      armed_r     <= 1'b1;
      mode_prev_r <= i_Mode_Next;
      step_prev_r <= i_Step;
      step_pend_r <= (mode_r == STEP) & step_edge_s & ~mode_edge_s;

      if (mode_edge_s) begin
        mode_r  <= mode_next_s;
        presc_r <= '0;
        if (mode_next_s == HOLD) begin
          blink_on_r  <= 1'b1;
          blink_cnt_r <= '0;
        end
      end else begin
        if (mode_r == AUTO) begin
          presc_r <= (presc_r == TICK_LAST) ? '0 : presc_r + 1'b1;
        end else begin
          presc_r <= '0;
        end
        if (mode_r == HOLD) begin
          if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= '0;
            blink_on_r  <= ~blink_on_r;
          end else begin
            blink_cnt_r <= blink_cnt_r + 1'b1;
          end
        end
      end

      // Clear beats everything; a mode edge swallows a coincident tick/step.
      if (i_Clear) begin
        count_r <= '0;
      end else if (!mode_edge_s && advance_s) begin
        count_r <= step_count(count_r, i_Dir);
      end
    end
  end

  // Per-digit segment pattern chosen from the registered mode and count.
  always_comb begin
    seg_next_s = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      case (mode_r)
        IDLE:    seg_next_s[7*k +: 7] = 7'b0111111;
        HOLD: begin
          if (blink_on_r) begin
            seg_next_s[7*k +: 7] = ~glyph(count_r[4*k +: 4]);
          end else begin
            seg_next_s[7*k +: 7] = 7'b1111111;
          end
        end
        default: seg_next_s[7*k +: 7] = ~glyph(count_r[4*k +: 4]);
      endcase
    end
  end

  // Segment output register, one cycle behind the count.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      seg_r <= '1;
    end else begin
      seg_r <= seg_next_s;
    end
  end

  assign o_Count    = count_r;
  assign o_Segments = seg_r;
  assign o_Mode     = mode_r;

endmodule

// File: tb/tb_count_7sd_multi.sv
// Directed plus randomized bench for count_7sd_multi; a BCD and a hex instance
// share stimulus and are checked against an integer-arithmetic reference model.
module tb_count_7sd_multi;

  localparam int ND = 2;
  localparam int TD = 4;
  localparam int BD = 3;

  logic        clk = 1'b0;
  logic        rst_n, mode_next, step, dir, clr;
  logic [7:0]  cnt_b, cnt_h;
  logic [13:0] seg_b, seg_h;
  logic [1:0]  mode_b, mode_h;

  always #5 clk = ~clk;

  count_7sd_multi #(.NUM_DIGITS(ND), .BCD(1'b1), .TICK_DIV(TD), .BLINK_DIV(BD)) u_bcd (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Mode_Next(mode_next), .i_Step(step),
    .i_Dir(dir), .i_Clear(clr), .o_Count(cnt_b), .o_Segments(seg_b), .o_Mode(mode_b));

  count_7sd_multi #(.NUM_DIGITS(ND), .BCD(1'b0), .TICK_DIV(TD), .BLINK_DIV(BD)) u_hex (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Mode_Next(mode_next), .i_Step(step),
    .i_Dir(dir), .i_Clear(clr), .o_Count(cnt_h), .o_Segments(seg_h), .o_Mode(mode_h));

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int base [2] = '{10, 16};
  int modv [2] = '{100, 256};

  int          m_mode, m_presc, m_bcnt;
  bit          m_bon, m_armed, m_pmn, m_pst, m_pend;
  int          m_val [2];
  logic [13:0] m_seg [2];
  int          vectors, miscompares;

  function automatic logic [7:0] to_digits(input int v, input int b);
    logic [7:0] r;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(v % b);
      v = v / b;
    end
    return r;
  endfunction

  function automatic logic [13:0] exp_seg(input int v, input int b);
    logic [13:0] r;
    for (int k = 0; k < ND; k++) begin
      if (m_mode == 0)             r[7*k +: 7] = 7'b0111111;
      else if (m_mode == 3 && !m_bon) r[7*k +: 7] = 7'b1111111;
      else                         r[7*k +: 7] = ~glyph_tab[v % b];
      v = v / b;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_presc = 0; m_bcnt = 0; m_bon = 1'b1;
    m_armed = 1'b0; m_pmn = 1'b0; m_pst = 1'b0; m_pend = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0;
      m_seg[i] = '1;
    end
  endtask

  // Advance the reference by one rising clock edge using the current inputs.
  task automatic model_step();
    bit me, se, adv;
    me  = m_armed && mode_next && !m_pmn;
    se  = m_armed && step && !m_pst;
    adv = !me && ((m_mode == 1 && m_presc == TD - 1) || (m_mode == 2 && m_pend));
    for (int i = 0; i < 2; i++) begin
      m_seg[i] = exp_seg(m_val[i], base[i]);
      if (clr)      m_val[i] = 0;
      else if (adv) m_val[i] = dir ? (m_val[i] + modv[i] - 1) % modv[i] : (m_val[i] + 1) % modv[i];
    end
    m_pend = (m_mode == 2) && se && !me;
    if (me) begin
      m_mode  = (m_mode + 1) % 4;
      m_presc = 0;
      if (m_mode == 3) begin
        m_bon = 1'b1; m_bcnt = 0;
      end
    end else begin
      m_presc = (m_mode == 1) ? (m_presc + 1) % TD : 0;
      if (m_mode == 3) begin
        if (m_bcnt == BD - 1) begin
          m_bcnt = 0; m_bon = !m_bon;
        end else begin
          m_bcnt++;
        end
      end
    end
    m_pmn = mode_next; m_pst = step; m_armed = 1'b1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    expect_val("bcd_count", 32'(cnt_b), 32'(to_digits(m_val[0], 10)));
    expect_val("hex_count", 32'(cnt_h), 32'(to_digits(m_val[1], 16)));
    expect_val("bcd_segs",  32'(seg_b), 32'(m_seg[0]));
    expect_val("hex_segs",  32'(seg_h), 32'(m_seg[1]));
    expect_val("bcd_mode",  32'(mode_b), 32'(m_mode));
    expect_val("hex_mode",  32'(mode_h), 32'(m_mode));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    vectors++;
    check_all();
  endtask

  task automatic press_mode();
    mode_next = 1'b1; cycle();
    mode_next = 1'b0; cycle();
  endtask

  initial begin
    int guard;
    vectors = 0; miscompares = 0;
    rst_n = 1'b1; mode_next = 1'b0; step = 1'b0; dir = 1'b0; clr = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    check_all();
    expect_val("reset_count", 32'(cnt_b), 32'h0);
    expect_val("reset_segs", 32'(seg_b), 32'h3FFF);
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    expect_val("idle_dash", 32'(seg_b), 32'({7'b0111111, 7'b0111111}));

    // AUTO: ten ticks in forty cycles
    press_mode();
    expect_val("auto_mode", 32'(mode_b), 32'd1);
    for (int i = 0; i < 39; i++) cycle();
    expect_val("auto_10_bcd", 32'(cnt_b), 32'h10);
    expect_val("auto_10_hex", 32'(cnt_h), 32'h0A);

    // run up to 99 then enter STEP just after a tick
    guard = 0;
    while (!(m_val[0] == 99 && m_presc == 0) && guard < 500) begin
      cycle(); guard++;
    end
    expect_val("preset_timeout", 32'(guard < 500), 32'd1);
    press_mode();
    expect_val("step_mode", 32'(mode_b), 32'd2);
    expect_val("preset_99", 32'(cnt_b), 32'h99);

    step = 1'b1; cycle();
    expect_val("step_latency", 32'(cnt_b), 32'h99);
    step = 1'b0; cycle();
    expect_val("step_wrap_bcd", 32'(cnt_b), 32'h00);
    expect_val("step_hex", 32'(cnt_h), 32'h64);

    clr = 1'b1; cycle(); clr = 1'b0;
    dir = 1'b1;
    step = 1'b1; cycle(); step = 1'b0; cycle();
    expect_val("down_bcd", 32'(cnt_b), 32'h99);
    expect_val("down_hex", 32'(cnt_h), 32'hFF);
    cycle();
    expect_val("seg_ff", 32'(seg_h), 32'({7'b0001110, 7'b0001110}));

    // coincident mode and step edges: mode wins
    mode_next = 1'b1; step = 1'b1; cycle();
    mode_next = 1'b0; step = 1'b0;
    expect_val("hold_mode", 32'(mode_b), 32'd3);
    for (int i = 0; i < 12; i++) cycle();
    expect_val("hold_frozen", 32'(cnt_b), 32'h99);

    clr = 1'b1; cycle(); clr = 1'b0;
    expect_val("hold_clear", 32'(cnt_b), 32'h00);

    press_mode(); press_mode();
    for (int i = 0; i < 6; i++) cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    check_all();
    expect_val("async_mode", 32'(mode_b), 32'd0);
    cycle();
    mode_next = 1'b1;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    expect_val("held_no_edge", 32'(mode_b), 32'd0);
    mode_next = 1'b0;
    cycle();

    for (int i = 0; i < 1500; i++) begin
      mode_next = ($urandom_range(0, 15) == 0);
      step      = ($urandom_range(0, 2) == 0);
      dir       = 1'($urandom_range(0, 1));
      clr       = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
